serial_stream_sched: RTL and testbench

Round-robin scheduler that feeds the serial sequence-detector `fsm` from two word-level requesters. It accepts 32-bit words over valid/ready handshakes and holds the detector in reset for a programmable gap. It then shifts the granted word into the detector MSB-first, one bit per clock, and pulses `done` when the last bit has been presented. It sits between word producers and `fsm`, driving `fsm`'s `a` and `rst` inputs directly.

---
 rtl/serial_stream_sched.sv | 141 ++++++++++++++
 tb/tb_serial_stream_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_stream_sched.sv
// serial_stream_sched: round-robin word scheduler that
// serializes granted words MSB-first into a detector.
module serial_stream_sched #(
  parameter int WIDTH = 32,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             bit_out,
  output logic             det_rst,
  output logic             busy,
  output logic             grant_id,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH);
  localparam int GCW = $clog2(GAP) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [BCW-1:0]   bcnt;
  logic [BCW-1:0]   bcnt_n;
  logic [GCW-1:0]   gcnt;
  logic [GCW-1:0]   gcnt_n;
  logic             ptr;
  logic             ptr_n;
  logic             gid_n;
  logic             idle;
  logic             g0;
  logic             g1;
  logic             bit_n;
  logic             det_rst_n;
  logic             busy_n;
  logic             done_n;

  // Round-robin grant; a lone valid always wins,
  // ptr only breaks ties. Held off while in reset.
  always_comb begin
    idle       = rst && (state == S_IDLE);
    g0         = idle && req0_valid &&
                 (!req1_valid || !ptr);
    g1         = idle && req1_valid &&
                 (!req0_valid || ptr);
    req0_ready = g0;
    req1_ready = g1;
  end

  // Next-state, counters, shift register and the
  // values the registered outputs take next cycle.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    ptr_n   = ptr;
    gid_n   = grant_id;
    unique case (state)
      S_IDLE: begin
        if (g0 || g1) begin
          state_n = S_GAP;
          shreg_n = g1 ? req1_data : req0_data;
          gid_n   = g1;
          ptr_n   = ~g1;
          gcnt_n  = GCW'(GAP - 1);
        end
      end
      S_GAP: begin
        if (gcnt == '0) begin
          state_n = S_SHIFT;
          bcnt_n  = BCW'(WIDTH - 1);
        end else begin
          gcnt_n = gcnt - 1'b1;
        end
      end
      S_SHIFT: begin
        shreg_n = {shreg[WIDTH-2:0], 1'b0};
        if (bcnt == '0) begin
          state_n = S_DONE;
        end else begin
          bcnt_n = bcnt - 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n    = (state_n != S_IDLE);
    det_rst_n = (state_n == S_IDLE) ||
                (state_n == S_GAP);
    bit_n     = (state_n == S_SHIFT) &&
                shreg_n[WIDTH-1];
    done_n    = (state_n == S_DONE);
  end

  // State and registered outputs; reset discards
  // any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      ptr      <= 1'b0;
      grant_id <= 1'b0;
      bit_out  <= 1'b0;
      det_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bcnt     <= bcnt_n;
      gcnt     <= gcnt_n;
      ptr      <= ptr_n;
      grant_id <= gid_n;
      bit_out  <= bit_n;
      det_rst  <= det_rst_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_stream_sched.sv
// tb_serial_stream_sched: table-driven grants plus
// hand sequences, checked against an expected-word queue.
module tb_serial_stream_sched;

  localparam int W = 32;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         bit_out;
  logic         det_rst;
  logic         busy;
  logic         grant_id;
  logic         done;

  always #5 clk = ~clk;

  serial_stream_sched #(.WIDTH(W), .GAP(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .bit_out    (bit_out),
    .det_rst    (det_rst),
    .busy       (busy),
    .grant_id   (grant_id),
    .done       (done)
  );

  typedef struct {
    bit           id;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    bit           v0;
    bit           v1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    bit           eid;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   cyc = 0;
  int   last_t = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h, required %h",
                  name, act, req);
  endtask

  task automatic push(input bit id,
                      input logic [W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_word(input bit drop,
                            input bit spaced);
    exp_t         e;
    int           tries;
    bit           seen;
    bit           gid;
    bit           ok;
    logic [W-1:0] w;
    tries = 0;
    seen  = 0;
    while (!seen && tries < 200) begin
      @(negedge clk);
      tries++;
      seen = req0_ready || req1_ready;
    end
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1'b0, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      chk("grant_timeout", 1'b0, 32'(tries), 200);
      return;
    end
    chk("one_ready", !(req0_ready && req1_ready),
        32'({req0_ready, req1_ready}), 32'(e.id ? 1 : 2));
    gid = req1_ready;
    chk("grant", gid == e.id, 32'(gid), 32'(e.id));
    if (spaced)
      chk("spacing", cyc - last_t == W + G + 2,
          32'(cyc - last_t), 32'(W + G + 2));
    last_t = cyc;
    @(posedge clk);
    #1;
    if (drop) begin
      if (gid) req1_valid = 1'b0;
      else req0_valid = 1'b0;
    end
    ok = 1'b1;
    for (int i = 0; i < G; i++) begin
      @(negedge clk);
      ok &= det_rst && busy && !bit_out && !done &&
            !req0_ready && !req1_ready;
    end
    chk("gap", ok, 32'({det_rst, busy, bit_out}), 32'h6);
    ok = 1'b1;
    w  = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      w = {w[W-2:0], bit_out};
      ok &= !det_rst && busy && !done;
    end
    chk("shift_ctl", ok, 32'({det_rst, busy, done}), 32'h2);
    chk("serial", w == e.data, w, e.data);
    @(negedge clk);
    chk("done", done && busy && !det_rst && !bit_out &&
        grant_id == e.id,
        32'({done, busy, det_rst, bit_out, grant_id}),
        32'({4'b1100, e.id}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 0, 32'h996208E9, 32'h0, 0};
    vecs[1] = '{0, 1, 32'h0, 32'hA5A50F0F, 1};
    vecs[2] = '{0, 1, 32'h0, 32'h13579BDF, 1};
    vecs[3] = '{0, 1, 32'h0, 32'h2468ACE0, 1};
    vecs[4] = '{1, 1, 32'h12345678, 32'h87654321, 0};
    vecs[5] = '{1, 1, 32'hCAFEF00D, 32'h600DD00D, 1};
    vecs[6] = '{1, 0, 32'hFFFFFFFF, 32'h0, 0};
    vecs[7] = '{1, 0, 32'h00000001, 32'h0, 0};
    vecs[8] = '{1, 1, 32'h80000000, 32'h7FFFFFFE, 1};

    rst        = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h11111111;
    req1_data  = 32'h22222222;
    repeat (3) begin
      @(negedge clk);
      chk("reset", !req0_ready && !req1_ready &&
          det_rst && !busy && !done && !bit_out &&
          !grant_id,
          32'({req0_ready, req1_ready, det_rst,
               busy, done, bit_out}), 32'h08);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b1;

    for (int k = 0; k < 9; k++) begin
      req0_valid = vecs[k].v0;
      req1_valid = vecs[k].v1;
      req0_data  = vecs[k].d0;
      req1_data  = vecs[k].d1;
      push(vecs[k].eid,
           vecs[k].eid ? vecs[k].d1 : vecs[k].d0);
      check_word(1'b1, 1'b0);
    end

    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h0975E39E;
    req1_data  = 32'h45443871;
    for (int k = 0; k < 4; k++)
      push(k[0], k[0] ? 32'h45443871 : 32'h0975E39E);
    for (int k = 0; k < 4; k++)
      check_word(1'b0, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    req0_valid = 1'b1;
    req0_data  = 32'hC3A55A3C;
    push(1'b0, 32'hC3A55A3C);
    fork
      check_word(1'b1, 1'b0);
      begin
        repeat (12) @(negedge clk);
        req1_data  = 32'hDEADBEEF;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("withdrawn_ready", !req1_ready,
            32'(req1_ready), 0);
        req1_valid = 1'b0;
      end
    join
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h0F0FF0F0;
    req1_data  = 32'h3C3CC3C3;
    push(1'b1, 32'h3C3CC3C3);
    check_word(1'b1, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    req0_valid = 1'b1;
    req0_data  = 32'h5168A874;
    begin
      int  tries;
      bit  seen;
      logic [W-1:0] d;
      d     = 32'h5168A874;
      tries = 0;
      seen  = 0;
      while (!seen && tries < 200) begin
        @(negedge clk);
        tries++;
        seen = req0_ready;
      end
      chk("mr_grant", seen, 32'(tries), 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      repeat (13) @(negedge clk);
      chk("mr_bit10", bit_out == d[W-11] && !det_rst,
          32'({det_rst, bit_out}), 32'(d[W-11]));
      rst        = 1'b0;
      req0_valid = 1'b1;
      req0_data  = 32'h01234567;
      req1_valid = 1'b1;
      req1_data  = 32'h76543210;
      @(negedge clk);
      chk("mr_reset", !busy && det_rst && !done &&
          !bit_out && !req0_ready && !req1_ready,
          32'({busy, det_rst, done, bit_out,
               req0_ready, req1_ready}), 32'h10);
      @(posedge clk);
      #1;
      rst = 1'b1;
    end
    push(1'b0, 32'h01234567);
    check_word(1'b1, 1'b0);
    req1_valid = 1'b0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
